// File: rtl/pong_pkg.sv
// Shared definitions for the pong paddle datapath: coordinate widths, screen
// limits, defaults and the ADC-average to screen-Y scaling.
`timescale 1ns/1ps
package pong_pkg;

  localparam int COORD_W      = 10;
  localparam int SAMPLE_W     = 8;
  localparam int SUM_W        = 10;
  localparam int Y_CENTER_DEF = 208;
  localparam int MAX_STEP_DEF = 8;

  localparam logic [COORD_W-1:0] Y_MAX = 10'd413;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_ACCUM = 2'd2,
    S_SCALE = 2'd3
  } state_e;

  // avg*1.625 with each term truncated: maps 0..255 onto 0..413.
  function automatic logic [COORD_W-1:0] scale_avg(input logic [SUM_W-1:0] sum);
    logic [COORD_W-1:0] avg;
    avg = {2'b00, sum[SUM_W-1:2]};
    return avg + (avg >> 1) + (avg >> 3);
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: 4-deep moving average of pot samples, scaling to a target Y,
// and a per-frame slew-limited walk of the paddle toward that target.
`timescale 1ns/1ps
module paddle_channel
  import pong_pkg::*;
#(
  parameter int Y_CENTER = Y_CENTER_DEF,
  parameter int MAX_STEP = MAX_STEP_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                capture_i,
  input  logic                scale_i,
  input  logic                commit_i,
  input  logic                frame_tick_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [COORD_W-1:0]  y_o
);

  localparam logic [COORD_W-1:0] Y_RST    = COORD_W'(Y_CENTER);
  localparam logic [COORD_W-1:0] STEP_MAX = COORD_W'(MAX_STEP);

  logic [SAMPLE_W-1:0] smp_q [4];
  logic [SAMPLE_W-1:0] smp_d [4];
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                primed_q, primed_d;
  logic [COORD_W-1:0]  pend_q, pend_d;
  logic [COORD_W-1:0]  target_q, target_d;
  logic [COORD_W-1:0]  y_q, y_d;
  logic [COORD_W-1:0]  diff, step;
  logic                up;

  always_comb begin
    smp_d    = smp_q;
    sum_d    = sum_q;
    primed_d = primed_q;
    if (capture_i) begin
      if (!primed_q) begin
        // First sample fills the whole window so the average starts settled.
        for (int i = 0; i < 4; i++) smp_d[i] = sample_i;
        sum_d    = {sample_i, 2'b00};
        primed_d = 1'b1;
      end else begin
        smp_d[0] = sample_i;
        for (int i = 1; i < 4; i++) smp_d[i] = smp_q[i-1];
        sum_d = sum_q + {2'b00, sample_i} - {2'b00, smp_q[3]};
      end
    end
  end

  // The new target is staged in pend_q and only becomes active after the
  // sample_valid cycle, so a frame step in that same cycle uses the old one.
  always_comb begin
    pend_d   = scale_i  ? scale_avg(sum_q) : pend_q;
    target_d = commit_i ? pend_q : target_q;
  end

  always_comb begin
    up   = (target_q >= y_q);
    diff = up ? (target_q - y_q) : (y_q - target_q);
    step = (diff > STEP_MAX) ? STEP_MAX : diff;
    y_d  = y_q;
    if (frame_tick_i) begin
      y_d = up ? (y_q + step) : (y_q - step);
      if (y_d > Y_MAX) y_d = Y_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) smp_q[i] <= '0;
      sum_q    <= '0;
      primed_q <= 1'b0;
      pend_q   <= Y_RST;
      target_q <= Y_RST;
      y_q      <= Y_RST;
    end else begin
      smp_q    <= smp_d;
      sum_q    <= sum_d;
      primed_q <= primed_d;
      pend_q   <= pend_d;
      target_q <= target_d;
      y_q      <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/paddle_tracker.sv
// Two-paddle tracker: sequences ADC conversions off the converter BUSY line
// and feeds both pot samples into per-paddle averaging/slew channels.
`timescale 1ns/1ps
module paddle_tracker
  import pong_pkg::*;
#(
  parameter int MAX_STEP = MAX_STEP_DEF,
  parameter int Y_CENTER = Y_CENTER_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                busy,
  input  logic [SAMPLE_W-1:0] data_ad0,
  input  logic [SAMPLE_W-1:0] data_ad1,
  input  logic                frame_tick,
  output logic [COORD_W-1:0]  barra_e_y,
  output logic [COORD_W-1:0]  barra_d_y,
  output logic                sample_valid,
  output state_e              dbg_state_o
);

  state_e state_q, state_d;
  logic   busy_prev_q;
  logic   valid_q;
  logic   capture, scale;

  // BUSY protocol: a low->high edge seen in S_IDLE starts a conversion; the
  // first low sample afterwards means the data pins hold the result.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    scale   = 1'b0;
    unique case (state_q)
      S_IDLE:  if (busy && !busy_prev_q) state_d = S_CONV;
      S_CONV:  if (!busy) state_d = S_ACCUM;
      S_ACCUM: begin
        capture = 1'b1;
        state_d = S_SCALE;
      end
      S_SCALE: begin
        scale   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // busy history resets high so a BUSY already high at release is not a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_prev_q <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_prev_q <= busy;
      valid_q     <= scale;
    end
  end

  paddle_channel #(.Y_CENTER(Y_CENTER), .MAX_STEP(MAX_STEP)) u_left (
    .clk          (clk),
    .reset        (reset),
    .capture_i    (capture),
    .scale_i      (scale),
    .commit_i     (valid_q),
    .frame_tick_i (frame_tick),
    .sample_i     (data_ad0),
    .y_o          (barra_e_y)
  );

  paddle_channel #(.Y_CENTER(Y_CENTER), .MAX_STEP(MAX_STEP)) u_right (
    .clk          (clk),
    .reset        (reset),
    .capture_i    (capture),
    .scale_i      (scale),
    .commit_i     (valid_q),
    .frame_tick_i (frame_tick),
    .sample_i     (data_ad1),
    .y_o          (barra_d_y)
  );

  assign sample_valid = valid_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_paddle_tracker.sv
// Directed bench for paddle_tracker: conversions, averaging, slew, frame/valid
// coincidence and reset-during-conversion, with hand-computed expectations.
`timescale 1ns/1ps
module tb_paddle_tracker;
  import pong_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         busy = 1'b0;
  logic [7:0]   data_ad0 = '0;
  logic [7:0]   data_ad1 = '0;
  logic         frame_tick = 1'b0;
  logic [9:0]   barra_e_y, barra_d_y;
  logic         sample_valid;
  state_e       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_cnt = 0;
  int valid_base;

  paddle_tracker dut (
    .clk          (clk),
    .reset        (reset),
    .busy         (busy),
    .data_ad0     (data_ad0),
    .data_ad1     (data_ad1),
    .frame_tick   (frame_tick),
    .barra_e_y    (barra_e_y),
    .barra_d_y    (barra_d_y),
    .sample_valid (sample_valid),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sample_valid === 1'b1) valid_cnt <= valid_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  // Called at a negedge with BUSY low for at least the previous edge.
  task automatic conv(input logic [7:0] a0, input logic [7:0] a1, input int hi,
                      input bit tick_on_valid);
    data_ad0 = a0;
    data_ad1 = a1;
    busy     = 1'b1;
    repeat (hi) @(negedge clk);
    busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("valid_early", sample_valid, 0);
    @(negedge clk);
    check("valid_lat2", sample_valid, 1);
    if (tick_on_valid) frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("valid_pulse", sample_valid, 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_left", barra_e_y, 208);
    check("rst_right", barra_d_y, 208);
    check("rst_valid", sample_valid, 0);
    check("rst_state", dbg_state, S_IDLE);

    // No conversions: frames cause no movement
    valid_base = valid_cnt;
    frames(3);
    check("idle_left", barra_e_y, 208);
    check("idle_right", barra_d_y, 208);
    check("idle_novalid", valid_cnt - valid_base, 0);

    // Full-scale left, zero right
    conv(8'd255, 8'd0, 3, 1'b0);
    check("no_move_on_valid_l", barra_e_y, 208);
    check("no_move_on_valid_r", barra_d_y, 208);
    frames(1);
    check("step1_left", barra_e_y, 216);
    check("step1_right", barra_d_y, 200);
    frames(24);
    check("step25_left", barra_e_y, 408);
    check("step25_right", barra_d_y, 8);
    frames(1);
    check("step26_left", barra_e_y, 413);
    check("step26_right", barra_d_y, 0);
    frames(2);
    check("hold_left", barra_e_y, 413);
    check("hold_right", barra_d_y, 0);

    // frame_tick coincident with sample_valid uses the old target
    do_reset();
    conv(8'd255, 8'd0, 2, 1'b1);
    check("coinc_left", barra_e_y, 208);
    check("coinc_right", barra_d_y, 208);
    frames(1);
    check("after_coinc_left", barra_e_y, 216);
    check("after_coinc_right", barra_d_y, 200);

    // Moving average: prime 0/255, then four conversions of 128
    do_reset();
    conv(8'd0, 8'd255, 2, 1'b0);
    conv(8'd128, 8'd128, 2, 1'b0);
    frames(30);
    check("avg32_left", barra_e_y, 52);
    check("avg223_right", barra_d_y, 361);
    conv(8'd128, 8'd128, 2, 1'b0);
    frames(1);
    check("avg64_step_left", barra_e_y, 60);
    check("avg191_step_right", barra_d_y, 353);
    frames(29);
    check("avg64_left", barra_e_y, 104);
    check("avg191_right", barra_d_y, 309);
    conv(8'd128, 8'd128, 2, 1'b0);
    frames(30);
    check("avg96_left", barra_e_y, 156);
    check("avg159_right", barra_d_y, 257);
    conv(8'd128, 8'd128, 2, 1'b0);
    frames(30);
    check("avg128_left", barra_e_y, 208);
    check("avg128_right", barra_d_y, 208);

    // Reset during conversion with BUSY still high at release
    do_reset();
    data_ad0 = 8'd255;
    data_ad1 = 8'd0;
    valid_base = valid_cnt;
    busy = 1'b1;
    repeat (2) @(negedge clk);
    check("conv_state", dbg_state, S_CONV);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    busy = 1'b0;
    repeat (6) @(negedge clk);
    check("rstconv_novalid", valid_cnt - valid_base, 0);
    check("rstconv_state", dbg_state, S_IDLE);
    frames(3);
    check("rstconv_left", barra_e_y, 208);
    check("rstconv_right", barra_d_y, 208);

    // One-cycle BUSY pulse still captures
    conv(8'd100, 8'd200, 1, 1'b0);
    frames(5);
    check("pulse_step5_left", barra_e_y, 168);
    check("pulse_step5_right", barra_d_y, 248);
    frames(10);
    check("pulse_left", barra_e_y, 162);
    check("pulse_right", barra_d_y, 325);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
